// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: load funct3 values, error codes,
// FSM states, and the accept-time load legality check.
package writeback_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

  // Illegal funct3 outranks misalignment.
  function automatic logic [1:0] load_check(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] code;
    code = ERR_NONE;
    case (f3)
      F3_LB, F3_LBU: code = ERR_NONE;
      F3_LH, F3_LHU: code = a[0] ? ERR_MISALIGN : ERR_NONE;
      F3_LW:         code = (a != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      default:       code = ERR_FUNCT3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/writeback_load_ext.sv
// Load data extractor: picks the byte/half/word addressed by addr_lo and
// sign- or zero-extends it according to funct3. Purely combinational.
module writeback_load_ext
  import writeback_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   i_funct3,
  input  logic [1:0]   i_addr_lo,
  input  logic [W-1:0] i_word,
  output logic [W-1:0] o_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_val = i_word;
    case (i_funct3)
      F3_LB:   o_val = {{(W-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_val = {{(W-8){1'b0}}, w_byte};
      F3_LH:   o_val = {{(W-16){w_half[15]}}, w_half};
      F3_LHU:  o_val = {{(W-16){1'b0}}, w_half};
      default: o_val = i_word;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: sole register-file writer. Retires ALU results directly
// and loads after the memory response; flags bad or timed-out loads.
module writeback
  import writeback_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_is_load,
  input  logic [4:0]   in_rd,
  input  logic [2:0]   in_funct3,
  input  logic [1:0]   in_addr_lo,
  input  logic [W-1:0] in_result,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  output logic         wen,
  output logic [4:0]   rd,
  output logic [W-1:0] rd_val,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [31:0]  retire_cnt,
  output wb_state_e    o_dbg_state
);

  // Handshake: a transfer happens on a posedge where in_valid && in_ready;
  // in_ready is high only in IDLE, so at most one instruction is in flight.

  localparam int CW = $clog2(TIMEOUT) + 1;

  wb_state_e      r_state, w_next_state;
  logic [2:0]     r_f3;
  logic [1:0]     r_addr;
  logic [4:0]     r_ld_rd;
  logic [CW-1:0]  r_tcnt, w_tcnt;
  logic           r_wen, w_wen;
  logic [4:0]     r_rd, w_rd;
  logic [W-1:0]   r_rd_val, w_rd_val;
  logic           r_err, w_err;
  logic [1:0]     r_err_code, w_err_code;
  logic [31:0]    r_retire_cnt, w_retire_cnt;
  logic           w_latch;
  logic [1:0]     w_chk;
  logic [W-1:0]   w_ext;

  writeback_load_ext #(.W(W)) u_load_ext (
    .i_funct3  (r_f3),
    .i_addr_lo (r_addr),
    .i_word    (mem_rdata),
    .o_val     (w_ext)
  );

  assign in_ready    = (r_state == WB_IDLE);
  assign wen         = r_wen;
  assign rd          = r_rd;
  assign rd_val      = r_rd_val;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign retire_cnt  = r_retire_cnt;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next_state = r_state;
    w_tcnt       = r_tcnt;
    w_wen        = 1'b0;
    w_rd         = r_rd;
    w_rd_val     = r_rd_val;
    w_err        = 1'b0;
    w_err_code   = r_err_code;
    w_retire_cnt = r_retire_cnt;
    w_latch      = 1'b0;
    w_chk        = load_check(in_funct3, in_addr_lo);
    case (r_state)
      WB_IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            w_wen        = (in_rd != REG_ZERO);
            w_retire_cnt = r_retire_cnt + 32'd1;
            if (in_rd != REG_ZERO) begin
              w_rd     = in_rd;
              w_rd_val = in_result;
            end
          end else if (w_chk != ERR_NONE) begin
            w_err      = 1'b1;
            w_err_code = w_chk;
          end else begin
            w_latch      = 1'b1;
            w_tcnt       = '0;
            w_next_state = WB_LOAD_WAIT;
          end
        end
      end
      WB_LOAD_WAIT: begin
        // A response on the final allowed cycle still completes normally.
        if (mem_rvalid) begin
          w_wen        = (r_ld_rd != REG_ZERO);
          w_retire_cnt = r_retire_cnt + 32'd1;
          w_next_state = WB_IDLE;
          if (r_ld_rd != REG_ZERO) begin
            w_rd     = r_ld_rd;
            w_rd_val = w_ext;
          end
        end else if (r_tcnt == CW'(TIMEOUT - 1)) begin
          w_err        = 1'b1;
          w_err_code   = ERR_TIMEOUT;
          w_next_state = WB_IDLE;
        end else begin
          w_tcnt = r_tcnt + CW'(1);
        end
      end
      default: w_next_state = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WB_IDLE;
      r_f3         <= 3'b000;
      r_addr       <= 2'b00;
      r_ld_rd      <= 5'd0;
      r_tcnt       <= '0;
      r_wen        <= 1'b0;
      r_rd         <= 5'd0;
      r_rd_val     <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_retire_cnt <= 32'd0;
    end else begin
      r_state      <= w_next_state;
      r_tcnt       <= w_tcnt;
      r_wen        <= w_wen;
      r_rd         <= w_rd;
      r_rd_val     <= w_rd_val;
      r_err        <= w_err;
      r_err_code   <= w_err_code;
      r_retire_cnt <= w_retire_cnt;
      if (w_latch) begin
        r_f3    <= in_funct3;
        r_addr  <= in_addr_lo;
        r_ld_rd <= in_rd;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Bench for the writeback stage: directed instructions push expected retire
// events into a queue; a negedge monitor pops and compares each wen/err pulse.
module tb_writeback;
  import writeback_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_is_load;
  logic [4:0]   in_rd;
  logic [2:0]   in_funct3;
  logic [1:0]   in_addr_lo;
  logic [W-1:0] in_result;
  logic         mem_rvalid;
  logic [W-1:0] mem_rdata;
  logic         wen, err;
  logic [4:0]   rd;
  logic [W-1:0] rd_val;
  logic [1:0]   err_code;
  logic [31:0]  retire_cnt;
  wb_state_e    dbg_state;

  writeback #(.W(W), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_is_load  (in_is_load),
    .in_rd       (in_rd),
    .in_funct3   (in_funct3),
    .in_addr_lo  (in_addr_lo),
    .in_result   (in_result),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .wen         (wen),
    .rd          (rd),
    .rd_val      (rd_val),
    .err         (err),
    .err_code    (err_code),
    .retire_cnt  (retire_cnt),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         is_err;
    logic [4:0]   rd;
    logic [W-1:0] val;
    logic [1:0]   code;
    logic [31:0]  ret;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_retire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [W-1:0] v);
    exp_t e;
    exp_retire = exp_retire + 32'd1;
    if (r != 5'd0) begin
      e = '{is_err: 1'b0, rd: r, val: v, code: 2'b00, ret: exp_retire};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e = '{is_err: 1'b1, rd: 5'd0, val: '0, code: c, ret: exp_retire};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (wen || err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event wen=%0b err=%0b rd=%0d rd_val=%0h", wen, err, rd, rd_val);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {62'd0, wen, err}, e.is_err ? 64'd1 : 64'd2);
        if (e.is_err) begin
          check("err_code", 64'(err_code), 64'(e.code));
        end else begin
          check("rd", 64'(rd), 64'(e.rd));
          check("rd_val", 64'(rd_val), 64'(e.val));
        end
        check("retire_cnt", 64'(retire_cnt), 64'(e.ret));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic ld, input logic [4:0] r, input logic [2:0] f3,
                      input logic [1:0] a, input logic [W-1:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    in_is_load = ld;
    in_rd      = r;
    in_funct3  = f3;
    in_addr_lo = a;
    in_result  = res;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input int delay, input logic [W-1:0] data);
    repeat (delay) @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wen"}, 64'(wen), 64'd0);
    check({tag, "_rd"}, 64'(rd), 64'd0);
    check({tag, "_rd_val"}, 64'(rd_val), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_err_code"}, 64'(err_code), 64'd0);
    check({tag, "_retire"}, 64'(retire_cnt), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_rd = 5'd0;
    in_funct3 = 3'b000; in_addr_lo = 2'b00; in_result = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    exp_retire = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // ALU write
    push_wr(5'd5, 32'hDEADBEEF);
    send(1'b0, 5'd5, 3'b000, 2'd0, 32'hDEADBEEF);

    // LB / LBU at byte 3
    push_wr(5'd10, 32'hFFFFFF80);
    send(1'b1, 5'd10, F3_LB, 2'd3, '0);
    check("ready_low_in_wait", 64'(in_ready), 64'd0);
    respond(3, 32'h80FFFFFF);
    push_wr(5'd10, 32'h00000080);
    send(1'b1, 5'd10, F3_LBU, 2'd3, '0);
    respond(3, 32'h80FFFFFF);

    // LH upper half, then misaligned LH
    push_wr(5'd11, 32'h00007FFF);
    send(1'b1, 5'd11, F3_LH, 2'd2, '0);
    respond(1, 32'h7FFF0000);
    push_err(ERR_MISALIGN);
    send(1'b1, 5'd12, F3_LH, 2'd1, '0);
    check("ready_after_err", 64'(in_ready), 64'd1);
    check("no_wen_on_err", 64'(wen), 64'd0);

    // LW timeout, then late rvalid ignored
    push_err(ERR_TIMEOUT);
    send(1'b1, 5'd3, F3_LW, 2'd0, '0);
    idle(15);
    check("ready_low_before_timeout", 64'(in_ready), 64'd0);
    idle(1);
    check("ready_after_timeout", 64'(in_ready), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA5555;
    idle(1);
    mem_rvalid = 1'b0;
    idle(1);

    // rvalid on the last allowed cycle wins
    push_wr(5'd7, 32'h12345678);
    send(1'b1, 5'd7, F3_LW, 2'd0, '0);
    respond(15, 32'h12345678);

    // ALU to x0 retires with no write
    push_wr(5'd0, 32'h55);
    send(1'b0, 5'd0, 3'b000, 2'd0, 32'h55);
    push_wr(5'd1, 32'h1);
    send(1'b0, 5'd1, 3'b000, 2'd0, 32'h1);

    // illegal funct3, priority over misalign, LW misaligned
    push_err(ERR_FUNCT3);
    send(1'b1, 5'd4, 3'b011, 2'd0, '0);
    push_err(ERR_FUNCT3);
    send(1'b1, 5'd4, 3'b110, 2'd1, '0);
    push_err(ERR_MISALIGN);
    send(1'b1, 5'd4, F3_LW, 2'd2, '0);

    // more extension patterns
    push_wr(5'd13, 32'h00008001);
    send(1'b1, 5'd13, F3_LHU, 2'd2, '0);
    respond(0, 32'h80010000);
    push_wr(5'd14, 32'hFFFF8001);
    send(1'b1, 5'd14, F3_LH, 2'd0, '0);
    respond(2, 32'h00008001);
    push_wr(5'd15, 32'h0000007F);
    send(1'b1, 5'd15, F3_LB, 2'd1, '0);
    respond(0, 32'h00007F00);
    push_wr(5'd0, 32'h0);
    send(1'b1, 5'd0, F3_LW, 2'd0, '0);
    respond(1, 32'hCAFEF00D);
    idle(2);

    // reset in LOAD_WAIT aborts silently
    send(1'b1, 5'd9, F3_LB, 2'd0, '0);
    idle(2);
    rst = 1'b1;
    idle(1);
    check_reset_outputs("mid_reset");
    exp_retire = 32'd0;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    idle(1);
    mem_rvalid = 1'b0;
    idle(2);
    check("no_err_after_reset", 64'(err), 64'd0);

    // 8 back-to-back ALU ops
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_wr(5'(i + 1), 32'h1000 + 32'(i));
      in_rd     = 5'(i + 1);
      in_result = 32'h1000 + 32'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    idle(2);

    // wrap of the retire counter
    force dut.r_retire_cnt = 32'hFFFFFFFE;
    #1;
    release dut.r_retire_cnt;
    exp_retire = 32'hFFFFFFFE;
    push_wr(5'd2, 32'h22);
    send(1'b0, 5'd2, 3'b000, 2'd0, 32'h22);
    push_wr(5'd3, 32'h33);
    send(1'b0, 5'd3, 3'b000, 2'd0, 32'h33);
    check("retire_wrapped", 64'(retire_cnt), 64'd0);

    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
